// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
//   opcode_t : the 16 operation codes on the 4-bit opcode input
//   state_t  : controller states (IDLE, MUL, SHIFT)
//   is_multi : true for opcodes that can take more than one cycle
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_PASSA = 4'b0000,
        OP_PASSB = 4'b0001,
        OP_NOT   = 4'b0010,
        OP_ADD   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_AND   = 4'b0101,
        OP_OR    = 4'b0110,
        OP_XOR   = 4'b0111,
        OP_ROR   = 4'b1000,
        OP_SRC   = 4'b1001,
        OP_SRL   = 4'b1010,
        OP_SLL   = 4'b1011,
        OP_MUL   = 4'b1100,
        OP_BSHR  = 4'b1101,
        OP_CMP   = 4'b1110,
        OP_RSVD  = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // BSHR by zero is still reported here; the controller finishes it in one cycle.
    function automatic logic is_multi(input opcode_t op);
        logic multi;
        case (op)
            OP_MUL:  multi = 1'b1;
            OP_BSHR: multi = 1'b1;
            default: multi = 1'b0;
        endcase
        return multi;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational core for every operation that finishes in one cycle.
// Ports:
//   a, b    : WIDTH-bit operands
//   cin     : carry in
//   opcode  : operation select (alu_seq_pkg::opcode_t encoding)
//   res     : 2*WIDTH-bit zero-extended result
//   cout    : carry / shifted-out bit for the ops that define one, else 0
// MUL, CMP and the reserved code give 0. BSHR gives a, which is its result
// for a zero shift distance (the only case the controller uses it for).
module alu_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [3:0]         opcode,
    output logic [2*WIDTH-1:0] res,
    output logic               cout
);

    localparam int RW = 2 * WIDTH;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] low_s;
    opcode_t          op_s;

    assign op_s   = opcode_t'(opcode);
    // Subtraction reuses the adder form a + ~b + cin; cin=1 yields a - b.
    assign sum_s  = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, cin};
    assign diff_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};

    // Select the low WIDTH result bits and carry for each single-cycle op.
    always_comb begin
        low_s = {WIDTH{1'b0}};
        cout  = 1'b0;
        case (op_s)
            OP_PASSA: low_s = a;
            OP_PASSB: low_s = b;
            OP_NOT:   low_s = ~a;
            OP_ADD: begin
                low_s = sum_s[WIDTH-1:0];
                cout  = sum_s[WIDTH];
            end
            OP_SUB: begin
                low_s = diff_s[WIDTH-1:0];
                cout  = diff_s[WIDTH];
            end
            OP_AND:   low_s = a & b;
            OP_OR:    low_s = a | b;
            OP_XOR:   low_s = a ^ b;
            OP_ROR:   low_s = {a[0], a[WIDTH-1:1]};
            OP_SRC: begin
                low_s = {cin, a[WIDTH-1:1]};
                cout  = a[0];
            end
            OP_SRL: begin
                low_s = {1'b0, a[WIDTH-1:1]};
                cout  = a[0];
            end
            OP_SLL: begin
                low_s = {a[WIDTH-2:0], 1'b0};
                cout  = a[WIDTH-1];
            end
            OP_BSHR:  low_s = a;
            default: begin
                low_s = {WIDTH{1'b0}};
                cout  = 1'b0;
            end
        endcase
    end

    // Widen to the full result; ADD also carries its carry-out into bit WIDTH.
    always_comb begin
        res = {RW{1'b0}};
        if (op_s == OP_ADD) begin
            res = {{(WIDTH-1){1'b0}}, sum_s};
        end else begin
            res = {{WIDTH{1'b0}}, low_s};
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered result/flags and a start/busy/done
// handshake. Single-cycle ops come from alu_comb; MUL (shift-add) and BSHR
// (one bit per cycle) run in the MUL and SHIFT states.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : operation request, taken only while busy=0
//   a, b, Cin  : operands and carry in
//   opcode     : operation select
//   busy       : a multi-cycle op is running
//   done       : one-cycle pulse when f and the flags update
//   f          : 2*WIDTH-bit registered result
//   Cout       : registered carry out
//   aGTb       : registered a > b (unsigned) of the operands taken at start
//   fEq0       : registered f == 0
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               Cin,
    input  logic [3:0]         opcode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] f,
    output logic               Cout,
    output logic               aGTb,
    output logic               fEq0
);

    localparam int RW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [WIDTH:0]   W_EXT    = (WIDTH+1)'(WIDTH);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [RW-1:0]    acc_r;
    logic [RW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] shreg_r;
    logic             agtb_pend_r;
    logic [RW-1:0]    f_r;
    logic             cout_r;
    logic             agtb_r;
    logic             feq0_r;
    logic             done_r;
    logic             busy_r;

    opcode_t          op_s;
    logic [RW-1:0]    comb_res_s;
    logic             comb_cout_s;
    logic             take_mul_s;
    logic             take_shift_s;
    logic [CNT_W-1:0] shift_cnt_s;
    logic [RW-1:0]    mul_acc_next_s;
    logic [WIDTH-1:0] shift_next_s;

    assign op_s = opcode_t'(opcode);

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a      (a),
        .b      (b),
        .cin    (Cin),
        .opcode (opcode),
        .res    (comb_res_s),
        .cout   (comb_cout_s)
    );

    // Dispatch of a start seen in IDLE: MUL always iterates, BSHR only for b > 0.
    always_comb begin
        take_mul_s   = 1'b0;
        take_shift_s = 1'b0;
        if (is_multi(op_s)) begin
            if (op_s == OP_MUL) begin
                take_mul_s = 1'b1;
            end else if (b != {WIDTH{1'b0}}) begin
                take_shift_s = 1'b1;
            end else begin
                take_shift_s = 1'b0;
            end
        end else begin
            take_mul_s   = 1'b0;
            take_shift_s = 1'b0;
        end
    end

    // Shift distance is clamped to WIDTH: further shifting only keeps zeros.
    always_comb begin
        shift_cnt_s = CNT_FULL;
        if ({1'b0, b} >= W_EXT) begin
            shift_cnt_s = CNT_FULL;
        end else begin
            shift_cnt_s = CNT_W'(b);
        end
    end

    // One shift-add step and one logical right-shift step.
    always_comb begin
        mul_acc_next_s = acc_r;
        if (mplier_r[0]) begin
            mul_acc_next_s = acc_r + mcand_r;
        end else begin
            mul_acc_next_s = acc_r;
        end
        shift_next_s = {1'b0, shreg_r[WIDTH-1:1]};
    end

    // Controller FSM with the result/flag registers and iteration datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            acc_r       <= {RW{1'b0}};
            mcand_r     <= {RW{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            shreg_r     <= {WIDTH{1'b0}};
            agtb_pend_r <= 1'b0;
            f_r         <= {RW{1'b0}};
            cout_r      <= 1'b0;
            agtb_r      <= 1'b0;
            feq0_r      <= 1'b1;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (take_mul_s) begin
                            mcand_r     <= {{WIDTH{1'b0}}, a};
                            mplier_r    <= b;
                            acc_r       <= {RW{1'b0}};
                            cnt_r       <= CNT_FULL;
                            agtb_pend_r <= (a > b);
                            busy_r      <= 1'b1;
                            state_r     <= MUL;
                        end else if (take_shift_s) begin
                            shreg_r     <= a;
                            cnt_r       <= shift_cnt_s;
                            agtb_pend_r <= (a > b);
                            busy_r      <= 1'b1;
                            state_r     <= SHIFT;
                        end else begin
                            f_r    <= comb_res_s;
                            cout_r <= comb_cout_s;
                            agtb_r <= (a > b);
                            feq0_r <= (comb_res_s == {RW{1'b0}});
                            done_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    acc_r    <= mul_acc_next_s;
                    mcand_r  <= {mcand_r[RW-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r - CNT_ONE;
                    // Last step: publish the accumulator including this step's add.
                    if (cnt_r == CNT_ONE) begin
                        f_r     <= mul_acc_next_s;
                        cout_r  <= 1'b0;
                        agtb_r  <= agtb_pend_r;
                        feq0_r  <= (mul_acc_next_s == {RW{1'b0}});
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= MUL;
                    end
                end
                SHIFT: begin
                    shreg_r <= shift_next_s;
                    cnt_r   <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        f_r     <= {{WIDTH{1'b0}}, shift_next_s};
                        cout_r  <= 1'b0;
                        agtb_r  <= agtb_pend_r;
                        feq0_r  <= (shift_next_s == {WIDTH{1'b0}});
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign f    = f_r;
    assign Cout = cout_r;
    assign aGTb = agtb_r;
    assign fEq0 = feq0_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=4). Stimulus pushes the
// reference result and its expected completion cycle; a negedge monitor pops
// on done and also checks busy and that outputs hold between completions.
module tb_alu_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset, start, Cin;
    logic [W-1:0]   a, b;
    logic [3:0]     opcode;
    logic           busy, done, Cout, aGTb, fEq0;
    logic [2*W-1:0] f;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .Cin    (Cin),
        .opcode (opcode),
        .busy   (busy),
        .done   (done),
        .f      (f),
        .Cout   (Cout),
        .aGTb   (aGTb),
        .fEq0   (fEq0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] f;
        logic           cout;
        logic           agtb;
        logic           feq0;
        int             done_cyc;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_x;
    int             errors = 0;
    int             checks = 0;
    int             free_e = 0;
    int             busy_lo = 0;
    int             busy_hi = -1;
    logic [2*W-1:0] hold_f = '0;
    logic           hold_cout = 1'b0, hold_agtb = 1'b0, hold_feq0 = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Reference: result, carry and completion latency straight from the opcode table.
    function automatic void model(input int av, input int bv, input int cv, input int op,
                                  output int fv, output int cov, output int lat);
        int mask;
        int s;
        mask = (1 << W) - 1;
        fv = 0; cov = 0; lat = 0;
        case (op)
            0:  fv = av;
            1:  fv = bv;
            2:  fv = ~av & mask;
            3:  begin s = av + bv + cv; fv = s; cov = s >> W; end
            4:  begin s = av + (~bv & mask) + cv; fv = s & mask; cov = (s >> W) & 1; end
            5:  fv = av & bv;
            6:  fv = av | bv;
            7:  fv = av ^ bv;
            8:  fv = ((av & 1) << (W - 1)) | (av >> 1);
            9:  begin fv = (cv << (W - 1)) | (av >> 1); cov = av & 1; end
            10: begin fv = av >> 1; cov = av & 1; end
            11: begin fv = (av << 1) & mask; cov = (av >> (W - 1)) & 1; end
            12: begin fv = av * bv; lat = W; end
            13: begin
                if (bv == 0) fv = av;
                else begin
                    fv  = (bv >= W) ? 0 : (av >> bv);
                    lat = (bv < W) ? bv : W;
                end
            end
            default: fv = 0;
        endcase
    endfunction

    // Drive one cycle of inputs; record an expectation if the model accepts the start.
    task automatic drive(input logic st, input int av, input int bv, input int cv, input int op);
        int   fv, cov, lat, e;
        exp_t x;
        @(negedge clk);
        start  = st;
        a      = av[W-1:0];
        b      = bv[W-1:0];
        Cin    = cv[0];
        opcode = op[3:0];
        e      = cyc + 1;
        if (st && e >= free_e) begin
            model(av, bv, cv, op, fv, cov, lat);
            x.f        = fv[2*W-1:0];
            x.cout     = cov[0];
            x.agtb     = (av > bv);
            x.feq0     = (fv == 0);
            x.done_cyc = e + lat;
            sb.push_back(x);
            free_e  = e + lat + 1;
            busy_lo = e;
            busy_hi = e + lat - 1;
        end
    endtask

    task automatic idle_cycle();
        drive(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 64) begin
            idle_cycle();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual=%0d pending required=0 cycle=%0d", sb.size(), cyc);
            sb.delete();
        end
        idle_cycle();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset   = 1'b1;
        start   = 1'b0;
        sb.delete();
        busy_lo   = 0;
        busy_hi   = -1;
        hold_f    = '0;
        hold_cout = 1'b0;
        hold_agtb = 1'b0;
        hold_feq0 = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        free_e = cyc + 1;
    endtask

    // Monitor: compare completions against the scoreboard, busy and held outputs.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            if (done === 1'b1) begin
                check("done_while_busy", 32'(busy), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    mon_x = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(mon_x.done_cyc));
                    check("f", 32'(f), 32'(mon_x.f));
                    check("Cout", 32'(Cout), 32'(mon_x.cout));
                    check("aGTb", 32'(aGTb), 32'(mon_x.agtb));
                    check("fEq0", 32'(fEq0), 32'(mon_x.feq0));
                    hold_f    = mon_x.f;
                    hold_cout = mon_x.cout;
                    hold_agtb = mon_x.agtb;
                    hold_feq0 = mon_x.feq0;
                end
            end else begin
                if (sb.size() != 0 && sb[0].done_cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_done: actual=0 required=1 cycle=%0d", sb[0].done_cyc);
                    mon_x = sb.pop_front();
                end
                check("hold_f", 32'(f), 32'(hold_f));
                check("hold_flags", 32'({Cout, aGTb, fEq0}), 32'({hold_cout, hold_agtb, hold_feq0}));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; Cin = 1'b0; opcode = 4'd0;

        do_reset(2);
        check("rst_f", 32'(f), 32'd0);
        check("rst_fEq0", 32'(fEq0), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_Cout", 32'(Cout), 32'd0);

        // ADD with carry out, SUB of equal operands
        drive(1'b1, 15, 1, 0, 3);
        drain();
        drive(1'b1, 5, 5, 1, 4);
        drain();

        // MUL with ignored starts while busy
        drive(1'b1, 15, 15, 0, 12);
        drive(1'b1, 3, 2, 0, 3);
        drive(1'b1, 7, 1, 1, 5);
        drive(1'b1, 1, 9, 0, 12);
        drain();

        // BSHR boundaries: in-range, zero and over-width distance
        drive(1'b1, 12, 2, 0, 13);
        drain();
        drive(1'b1, 12, 0, 0, 13);
        drain();
        drive(1'b1, 12, 7, 0, 13);
        drain();

        // Back-to-back single-cycle ops, then start on MUL's done cycle
        drive(1'b1, 9, 6, 0, 3);
        drive(1'b1, 9, 6, 0, 7);
        drive(1'b1, 9, 6, 1, 9);
        drive(1'b1, 6, 7, 0, 12);
        repeat (4) drive(1'b1, 10, 3, 0, 11);
        drain();

        // Reset two cycles into a MUL: no done may follow
        drive(1'b1, 15, 15, 0, 12);
        idle_cycle();
        do_reset(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_f", 32'(f), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (6) idle_cycle();
        drive(1'b1, 8, 3, 1, 3);
        drain();

        // Randomised traffic, including starts while busy and changing inputs
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 15));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
